// File: rtl/bfxp_pkg.sv
// Shared definitions for the bit-field extract/deposit units: data width,
// shift-amount width and the field-mask generator.
package bfxp_pkg;

   localparam int XLEN    = 32;
   localparam int SHAMT_W = 5;

   // Low-order mask of 'len' ones; a length code of zero means a full-width field.
   function automatic logic [XLEN-1:0] bfxp_mask_gen(input logic [SHAMT_W-1:0] len);
      logic [XLEN-1:0] m;
      if (len == '0) begin
         m = {XLEN{1'b1}};
      end else begin
         m = ~({XLEN{1'b1}} << len);
      end
      return m;
   endfunction

endpackage

// File: rtl/simple_bfdep_if.sv
// Request/response bundle for the bit-field deposit unit: a valid/ready
// request channel carrying the operands and a valid/ready result channel.
interface simple_bfdep_if #(
   parameter int XLEN = bfxp_pkg::XLEN
);

   logic                         in_valid;
   logic                         in_ready;
   logic [XLEN-1:0]              rs1;
   logic [XLEN-1:0]              rs2;
   logic [bfxp_pkg::SHAMT_W-1:0] start;
   logic [bfxp_pkg::SHAMT_W-1:0] len;
   logic [bfxp_pkg::SHAMT_W-1:0] dest;
   logic                         out_valid;
   logic                         out_ready;
   logic [XLEN-1:0]              rd;

   modport master (
      output in_valid, rs1, rs2, start, len, dest, out_ready,
      input  in_ready, out_valid, rd
   );

   modport slave (
      input  in_valid, rs1, rs2, start, len, dest, out_ready,
      output in_ready, out_valid, rd
   );

endinterface

// File: rtl/bfxp_mask.sv
// Combinational field-mask generator, shared with the extract-place unit.
module bfxp_mask
   import bfxp_pkg::*;
(
   input  logic [SHAMT_W-1:0] len,
   output logic [XLEN-1:0]    mask
);

   assign mask = bfxp_mask_gen(len);

endmodule

// File: rtl/simple_bfdep.sv
// Two-stage bit-field deposit: extracts a field of rs1 and writes it into
// rs2 at a new position. Stage 1 holds the extracted field and its mask,
// stage 2 holds the merged result. Full valid/ready flow control with
// at most two requests buffered.
module simple_bfdep
   import bfxp_pkg::*;
#(
   parameter int XLEN = bfxp_pkg::XLEN
) (
   input  logic          clock,
   input  logic          reset,
   simple_bfdep_if.slave bus
);

   // Merge a field into the background word; bits pushed past the top are lost.
   function automatic logic [XLEN-1:0] deposit(
      input logic [XLEN-1:0]    bg,
      input logic [XLEN-1:0]    fld,
      input logic [XLEN-1:0]    msk,
      input logic [SHAMT_W-1:0] pos
   );
      return (bg & ~(msk << pos)) | (fld << pos);
   endfunction

   logic [XLEN-1:0]    mask_c;
   logic [XLEN-1:0]    field_c;
   logic               accept;
   logic               adv_p1;

   logic               vld_p1;
   logic [XLEN-1:0]    field_p1;
   logic [XLEN-1:0]    mask_p1;
   logic [XLEN-1:0]    rs2_p1;
   logic [SHAMT_W-1:0] dest_p1;

   logic               vld_p2;
   logic [XLEN-1:0]    rd_p2;

   bfxp_mask u_mask (
      .len  (bus.len),
      .mask (mask_c)
   );

   // Logical right shift zero-fills, so source bits above bit 31 read as 0.
   assign field_c = (bus.rs1 >> bus.start) & mask_c;

   // Stage 1 may hand over whenever stage 2 is empty or being drained.
   assign adv_p1       = !vld_p2 || bus.out_ready;
   assign bus.in_ready = !vld_p1 || adv_p1;
   assign accept       = bus.in_valid && bus.in_ready;

   // ---- stage boundary: operands -> p1 ----

   // Pipeline occupancy; the only state cleared by reset besides the result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
         end
         if (adv_p1) begin
            vld_p2 <= vld_p1;
         end
      end
   end

   // Stage-1 operand capture, only on an accepted request.
   always_ff @(posedge clock) begin
      if (accept) begin
         field_p1 <= field_c;
         mask_p1  <= mask_c;
         rs2_p1   <= bus.rs2;
         dest_p1  <= bus.dest;
      end
   end

   // ---- stage boundary: p1 -> p2 ----

   // Result register; kept at zero until the first result and frozen while stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_p2 <= '0;
      end else if (adv_p1 && vld_p1) begin
         rd_p2 <= deposit(rs2_p1, field_p1, mask_p1, dest_p1);
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.rd        = rd_p2;

endmodule

// File: tb/tb_simple_bfdep.sv
// Directed and randomized bench for simple_bfdep.
module tb_simple_bfdep;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  start;
      logic [4:0]  len;
      logic [4:0]  dest;
      logic [31:0] rd;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[9];

   always #5 clock = ~clock;

   simple_bfdep_if #(.XLEN(32)) bus();

   simple_bfdep #(.XLEN(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Bit-by-bit reference of the deposit operation.
   function automatic logic [31:0] ref_bf(input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [4:0] start, input logic [4:0] len,
                                          input logic [4:0] dest);
      logic [31:0] r;
      int w;
      w = (len == 5'd0) ? 32 : int'(len);
      for (int i = 0; i < 32; i++) begin
         int k;
         k = i - int'(dest);
         if (k >= 0 && k < w) begin
            int s;
            s = int'(start) + k;
            r[i] = (s < 32) ? rs1[s] : 1'b0;
         end else begin
            r[i] = rs2[i];
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input vec_t v);
      bus.in_valid = 1'b1;
      bus.rs1      = v.rs1;
      bus.rs2      = v.rs2;
      bus.start    = v.start;
      bus.len      = v.len;
      bus.dest     = v.dest;
   endtask

   // Idle with junk on the operand lines; it must be ignored.
   task automatic idle();
      bus.in_valid = 1'b0;
      bus.rs1      = $urandom;
      bus.rs2      = $urandom;
      bus.start    = 5'($urandom);
      bus.len      = 5'($urandom);
      bus.dest     = 5'($urandom);
   endtask

   initial begin
      int          sent;
      int          got;
      int          cyc;
      bit          pending;
      bit          stall_prev;
      logic [31:0] rd_prev;
      logic [31:0] q[$];
      vec_t        v;

      vecs[0] = '{32'h12345678, 32'hFFFFFFFF, 5'd8,  5'd8,  5'd16, 32'hFF56FFFF};
      vecs[1] = '{32'hDEADBEEF, 32'h00000000, 5'd0,  5'd0,  5'd0,  32'hDEADBEEF};
      vecs[2] = '{32'h000000FF, 32'h00000000, 5'd0,  5'd8,  5'd28, 32'hF0000000};
      vecs[3] = '{32'hA0000000, 32'h12345678, 5'd28, 5'd8,  5'd0,  32'h1234560A};
      vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 5'd4,  5'd4,  5'd0,  32'h0000000F};
      vecs[5] = '{32'h0000000F, 32'h00000000, 5'd0,  5'd1,  5'd31, 32'h80000000};
      vecs[6] = '{32'h00000000, 32'hFFFFFFFF, 5'd0,  5'd16, 5'd8,  32'hFF0000FF};
      vecs[7] = '{32'h87654321, 32'hFFFFFFFF, 5'd31, 5'd0,  5'd0,  32'h00000001};
      vecs[8] = '{32'h12345678, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd4,  32'h2345678F};

      // Reset state
      reset         = 1'b1;
      bus.out_ready = 1'b0;
      idle();
      #1;
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst rd", bus.rd, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
      check("post-rst rd", bus.rd, 32'd0);

      // Single requests, latency and result
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         drive_req(vecs[i]);
         bus.out_ready = 1'b1;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
         @(negedge clock);
         idle();
         #1;
         check($sformatf("vec%0d early out_valid", i), 32'(bus.out_valid), 32'd0);
         @(negedge clock);
         #1;
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("vec%0d rd", i), bus.rd, vecs[i].rd);
      end
      @(negedge clock);

      // Backpressure: three back-to-back requests with the consumer stalled
      bus.out_ready = 1'b0;
      drive_req(vecs[0]);
      #1;
      check("bp in_ready A", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      drive_req(vecs[1]);
      #1;
      check("bp in_ready B", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      drive_req(vecs[2]);
      #1;
      check("bp in_ready full", 32'(bus.in_ready), 32'd0);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp rd A", bus.rd, vecs[0].rd);
      @(negedge clock);
      #1;
      check("bp in_ready still full", 32'(bus.in_ready), 32'd0);
      check("bp rd A held", bus.rd, vecs[0].rd);
      bus.out_ready = 1'b1;
      #1;
      check("bp in_ready on pop", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      idle();
      #1;
      check("bp out_valid B", 32'(bus.out_valid), 32'd1);
      check("bp rd B", bus.rd, vecs[1].rd);
      @(negedge clock);
      #1;
      check("bp out_valid C", 32'(bus.out_valid), 32'd1);
      check("bp rd C", bus.rd, vecs[2].rd);
      @(negedge clock);
      #1;
      check("bp drained", 32'(bus.out_valid), 32'd0);

      // Reset with two requests in flight
      bus.out_ready = 1'b0;
      drive_req(vecs[3]);
      @(negedge clock);
      drive_req(vecs[4]);
      @(negedge clock);
      idle();
      #1;
      check("mid-rst out_valid before", 32'(bus.out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid-rst out_valid", 32'(bus.out_valid), 32'd0);
      check("mid-rst rd", bus.rd, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid-rst in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         check("mid-rst no stale out_valid", 32'(bus.out_valid), 32'd0);
         check("mid-rst rd zero", bus.rd, 32'd0);
      end

      // Random streaming with random backpressure
      sent       = 0;
      got        = 0;
      cyc        = 0;
      pending    = 1'b0;
      stall_prev = 1'b0;
      rd_prev    = '0;
      while (got < 1000 && cyc < 20000) begin
         @(negedge clock);
         cyc++;
         if (stall_prev) begin
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall rd", bus.rd, rd_prev);
         end
         if (!pending) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
               v.rs1   = $urandom;
               v.rs2   = $urandom;
               v.start = 5'($urandom);
               v.len   = 5'($urandom);
               v.dest  = 5'($urandom);
               v.rd    = '0;
               drive_req(v);
               pending = 1'b1;
            end else begin
               idle();
            end
         end
         bus.out_ready = 1'($urandom_range(0, 1));
         #1;
         stall_prev = bus.out_valid && !bus.out_ready;
         rd_prev    = bus.rd;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               check("stream unexpected result", 32'(q.size()), 32'd1);
            end else begin
               check("stream rd", bus.rd, q.pop_front());
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_bf(bus.rs1, bus.rs2, bus.start, bus.len, bus.dest));
            sent++;
            pending = 1'b0;
         end
      end
      check("stream results received", 32'(got), 32'd1000);
      check("stream queue empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/simple_bfdep.md
SIMPLE_BFDEP -- requirements
Module: simple_bfdep

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port rs1  input  32  source word holding the field.
REQ-007 SHALL have port rs2  input  32  background word into which the field is deposited.
REQ-008 SHALL have port start  input  5  LSB position of the field in rs1.
REQ-009 SHALL have port len  input  5  field width; 0 encodes 32.
REQ-010 SHALL have port dest  input  5  LSB position of the field in rd.
REQ-011 SHALL have port out_valid  output  1  rd is valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready at a clock edge.
REQ-013 SHALL have port rd  output  32  result.

Function
REQ-014 SHALL compute mask = (len==0) ? 0xFFFFFFFF : (1<<len)-1, evaluated at 32-bit width.
REQ-015 SHALL compute field = (rs1 >> start) & mask; bits shifted in from above bit 31 are 0.
REQ-016 SHALL compute rd = (rs2 & ~(mask<<dest)) | (field<<dest), truncating both shifted terms to 32 bits; field bits that land above bit 31 are discarded.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers field, mask and rs2 together with dest; stage 2 registers rd.
REQ-018 SHALL present rd with out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-019 SHALL sustain one accepted request per cycle when out_ready is continuously high.
REQ-020 SHALL hold in_ready = !s1_valid || s1 advances this cycle, where s1 advances = !s2_valid || out_ready; this is combinational on out_ready only, never on in_valid.
REQ-021 SHALL hold rd and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL buffer at most 2 requests; with out_ready low, in_ready deasserts after the 2nd acceptance.
REQ-023 SHALL deliver results in acceptance order, with no loss and no duplication.
REQ-024 SHALL, on a simultaneous output pop and input accept in the same cycle, move all stages forward in that cycle.
REQ-025 SHALL ignore rs1, rs2, start, len and dest when in_valid is low.

Reset
REQ-026 SHALL, when reset is asserted, immediately clear s1_valid, out_valid and in_ready-related state, including mid-operation; in-flight requests are dropped.
REQ-027 SHALL drive rd = 0 and out_valid = 0 during reset and until the first result.
REQ-028 SHALL drive in_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL place XLEN, the shift-amount width (5) and the mask-generation function in shared package bfxp_pkg.
REQ-030 SHALL instantiate one sub-module, bfxp_mask (len -> 32-bit mask, combinational), reusable by the extract-place unit.

Verification
REQ-031 SHALL cover: rs1=0x12345678, start=8, len=8, dest=16, rs2=0xFFFFFFFF -> rd=0xFF56FFFF two cycles later.
REQ-032 SHALL cover: rs1=0xDEADBEEF, start=0, len=0, dest=0, rs2=0x00000000 -> rd=0xDEADBEEF (full-width field).
REQ-033 SHALL cover: rs1=0x000000FF, start=0, len=8, dest=28, rs2=0x0 -> rd=0xF0000000 (upper field bits discarded); and rs1=0xA0000000, start=28, len=8, dest=0, rs2=0x12345678 -> rd=0x1234560A (zero fill above bit 31).
REQ-034 SHALL cover backpressure: hold out_ready=0 and offer 3 back-to-back requests -> in_ready=0 after 2 accepts, rd held stable; then set out_ready=1 -> 3 results in order on consecutive cycles.
REQ-035 SHALL cover streaming: 1000 random requests with out_ready toggled randomly -> every rd matches the REQ-016 reference model, in order.
REQ-036 SHALL cover reset mid-operation: assert reset with 2 requests in flight -> out_valid=0 and rd=0 immediately; after release, in_ready=1 and no stale result ever appears.
